// File: rtl/step_run_ctrl_pkg.sv
// Shared types and helpers for the step/run clock-enable controller.
package step_run_ctrl_pkg;

  typedef enum logic [1:0] {
    S_HALTED = 2'd0,
    S_RUN    = 2'd1,
    S_BURST  = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  localparam int DEF_CNT_W = 16;

  // Never returns less than 1 so a degenerate timer still has a legal width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/step_run_ctrl_if.sv
// Button/CPU-side signal bundle for step_run_ctrl.
interface step_run_ctrl_if
  import step_run_ctrl_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int CNT_W  = DEF_CNT_W
);
  logic              run_btn;
  logic              step_btn;
  logic [STEP_W-1:0] burst;
  logic              halt_req;
  logic              cen;
  logic              running;
  logic              step_active;
  logic [CNT_W-1:0]  step_cnt;

  modport master (
    output run_btn, step_btn, burst, halt_req,
    input  cen, running, step_active, step_cnt
  );

  modport slave (
    input  run_btn, step_btn, burst, halt_req,
    output cen, running, step_active, step_cnt
  );
endinterface

// File: rtl/step_run_ctrl_btn_edge.sv
// Two-register rising-edge detector; history resets high so a held button gives no event.
module step_run_ctrl_btn_edge (
  input  logic c_i,
  input  logic r_n_i,
  input  logic btn_i,
  output logic ev_o
);
  logic d0_q, d1_q;

  always_ff @(posedge c_i or negedge r_n_i) begin
    if (!r_n_i) begin
      d0_q <= 1'b1;
      d1_q <= 1'b1;
    end else begin
      d0_q <= btn_i;
      d1_q <= d0_q;
    end
  end

  assign ev_o = d0_q & ~d1_q;
endmodule

// File: rtl/step_run_ctrl.sv
// Step/run controller: button events and HALT_REQ drive the CPU clock enable.
// Build option STEP_AUTO_REPEAT_EN adds the HOLD state and hold/repeat timer.
//
//   state    | meaning
//   S_HALTED | CPU stopped, waiting for a run or step event
//   S_RUN    | free-running, CEN high every cycle
//   S_BURST  | CEN high for the latched number of cycles
//   S_HOLD   | STEP still held after a burst, timing auto-repeat
module step_run_ctrl
  import step_run_ctrl_pkg::*;
#(
  parameter int STEP_W     = 8,
  parameter int HOLD_LEN   = 1000000,
  parameter int REPEAT_LEN = 250000,
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic            c_i,
  input logic            r_n_i,
  step_run_ctrl_if.slave bus
);
  localparam int TMR_W = clog2((HOLD_LEN > REPEAT_LEN) ? HOLD_LEN : REPEAT_LEN);
  localparam logic [STEP_W-1:0] ONE_S = STEP_W'(1);
  localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic              cen_q, running_q, step_active_q;
  logic              run_ev, step_ev, run_ev_q, step_ev_q;
  logic              start_burst;

  step_run_ctrl_btn_edge u_run_edge  (.c_i(c_i), .r_n_i(r_n_i), .btn_i(bus.run_btn),  .ev_o(run_ev));
  step_run_ctrl_btn_edge u_step_edge (.c_i(c_i), .r_n_i(r_n_i), .btn_i(bus.step_btn), .ev_o(step_ev));

`ifdef STEP_AUTO_REPEAT_EN
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_LEN - 1);
  localparam logic [TMR_W-1:0] REP_LD  = TMR_W'(REPEAT_LEN - 1);
  localparam logic [TMR_W-1:0] ONE_T   = TMR_W'(1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rpt_q, rpt_d;  // set once a burst came from HOLD

  always_ff @(posedge c_i or negedge r_n_i) begin
    if (!r_n_i) begin
      tmr_q <= '0;
      rpt_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      rpt_q <= rpt_d;
    end
  end
`else
  logic [TMR_W-1:0] unused_tmr;
  assign unused_tmr = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_cnt_d  = step_cnt_q;
    start_burst = 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
    tmr_d       = tmr_q;
    rpt_d       = rpt_q;
`endif
    case (state_q)
      S_HALTED: begin
        if (run_ev_q) begin
          if (!bus.halt_req) state_d = S_RUN;
        end else if (step_ev_q) begin
          start_burst = 1'b1;
`ifdef STEP_AUTO_REPEAT_EN
          rpt_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (run_ev_q || bus.halt_req) state_d = S_HALTED;
      end
      S_BURST: begin
        if (bus.halt_req) begin
          state_d = S_HALTED;
        end else if (run_ev_q) begin
          state_d = S_RUN;
        end else if (cnt_q == '0) begin
`ifdef STEP_AUTO_REPEAT_EN
          if (bus.step_btn) begin
            state_d = S_HOLD;
            tmr_d   = rpt_q ? REP_LD : HOLD_LD;
          end else begin
            state_d = S_HALTED;
          end
`else
          state_d = S_HALTED;
`endif
        end else begin
          cnt_d = cnt_q - ONE_S;
        end
      end
      S_HOLD: begin
`ifdef STEP_AUTO_REPEAT_EN
        if (bus.halt_req) begin
          state_d = S_HALTED;
        end else if (run_ev_q) begin
          state_d = S_RUN;
        end else if (!bus.step_btn) begin
          state_d = S_HALTED;
        end else if (tmr_q == '0) begin
          start_burst = 1'b1;
          rpt_d       = 1'b1;
        end else begin
          tmr_d = tmr_q - ONE_T;
        end
`else
        state_d = S_HALTED;
`endif
      end
      default: state_d = S_HALTED;
    endcase

    // A BURST input of 0 still yields one CEN cycle.
    if (start_burst) begin
      state_d    = S_BURST;
      cnt_d      = (bus.burst == '0) ? '0 : bus.burst - ONE_S;
      step_cnt_d = step_cnt_q + ONE_C;
    end
  end

  always_ff @(posedge c_i or negedge r_n_i) begin
    if (!r_n_i) begin
      state_q       <= S_HALTED;
      cnt_q         <= '0;
      step_cnt_q    <= '0;
      run_ev_q      <= 1'b0;
      step_ev_q     <= 1'b0;
      cen_q         <= 1'b0;
      running_q     <= 1'b0;
      step_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      step_cnt_q    <= step_cnt_d;
      run_ev_q      <= run_ev;
      step_ev_q     <= step_ev;
      cen_q         <= (state_d == S_RUN) || (state_d == S_BURST);
      running_q     <= (state_d == S_RUN);
      step_active_q <= (state_d == S_BURST);
    end
  end

  assign bus.cen         = cen_q;
  assign bus.running     = running_q;
  assign bus.step_active = step_active_q;
  assign bus.step_cnt    = step_cnt_q;
endmodule

// File: tb/tb_step_run_ctrl.sv
// Directed bench for step_run_ctrl; expectations adapt to STEP_AUTO_REPEAT_EN.
module tb_step_run_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   exp_cnt;

  step_run_ctrl_if #(.STEP_W(8), .CNT_W(4)) bus ();

  step_run_ctrl #(
    .STEP_W(8), .HOLD_LEN(20), .REPEAT_LEN(8), .CNT_W(4)
  ) dut (
    .c_i  (clk),
    .r_n_i(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle STEP pulse, then watch CEN for k negedges (index 1 = first after the pulse).
  task automatic step_watch(input int k, output int first, output int last,
                            output int len, output int mism);
    first = -1; last = -1; len = 0; mism = 0;
    bus.step_btn = 1'b1;
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      bus.step_btn = 1'b0;
      if (bus.cen) begin
        if (first < 0) first = i;
        last = i;
        len++;
      end
      if (bus.cen != bus.step_active) mism++;
    end
  endtask

  task automatic run_pulse();
    bus.run_btn = 1'b1;
    @(negedge clk);
    bus.run_btn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic halt_pulse();
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
  endtask

  initial begin
    int first, last, len, mism, lows;
    int rise[8];
    int nr;
    int exp_rise[5];
    logic prev;
    n_tests = 0; n_fail = 0; exp_cnt = 0;
    rst_n = 1'b0;
    bus.run_btn = 1'b0; bus.step_btn = 1'b1; bus.burst = 8'd5; bus.halt_req = 1'b0;

    // STEP held through reset release: no burst.
    repeat (3) @(negedge clk);
    chk("rst_cen", 32'(bus.cen), 0);
    chk("rst_running", 32'(bus.running), 0);
    chk("rst_step_active", 32'(bus.step_active), 0);
    chk("rst_step_cnt", 32'(bus.step_cnt), 0);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cen || bus.step_active) lows++;
    end
    chk("held_thru_reset_cen_cycles", 32'(lows), 0);
    chk("held_thru_reset_cnt", 32'(bus.step_cnt), 0);
    bus.step_btn = 1'b0;
    repeat (3) @(negedge clk);

    // BURST=5 and BURST=0.
    bus.burst = 8'd5;
    step_watch(15, first, last, len, mism);
    exp_cnt = (exp_cnt + 1) % 16;
    chk("b5_first", 32'(first), 3);
    chk("b5_last", 32'(last), 7);
    chk("b5_len", 32'(len), 5);
    chk("b5_step_active", 32'(mism), 0);
    chk("b5_cnt", 32'(bus.step_cnt), 32'(exp_cnt));
    bus.burst = 8'd0;
    step_watch(10, first, last, len, mism);
    exp_cnt = (exp_cnt + 1) % 16;
    chk("b0_first", 32'(first), 3);
    chk("b0_len", 32'(len), 1);
    chk("b0_step_active", 32'(mism), 0);
    chk("b0_cnt", 32'(bus.step_cnt), 32'(exp_cnt));

    // Free run, halted by a one-cycle HALT_REQ at cycle 50.
    run_pulse();
    chk("run_running", 32'(bus.running), 1);
    lows = 0;
    for (int i = 4; i <= 50; i++) begin
      @(negedge clk);
      if (!bus.cen || !bus.running) lows++;
    end
    chk("run_cen_continuous", 32'(lows), 0);
    halt_pulse();
    chk("halt_cen", 32'(bus.cen), 0);
    chk("halt_running", 32'(bus.running), 0);
    run_pulse();
    chk("resume_running", 32'(bus.running), 1);
    chk("resume_cen", 32'(bus.cen), 1);
    run_pulse();
    chk("run_toggle_off", 32'(bus.running), 0);
    chk("run_toggle_off_cen", 32'(bus.cen), 0);

    // Run and step together: run wins, no burst counted.
    bus.run_btn = 1'b1; bus.step_btn = 1'b1;
    @(negedge clk);
    bus.run_btn = 1'b0; bus.step_btn = 1'b0;
    repeat (2) @(negedge clk);
    chk("run_wins_running", 32'(bus.running), 1);
    chk("run_wins_cnt", 32'(bus.step_cnt), 32'(exp_cnt));
    halt_pulse();

    // Run press while HALT_REQ held stays halted.
    bus.halt_req = 1'b1;
    run_pulse();
    @(negedge clk);
    chk("run_blocked_by_halt", 32'(bus.running), 0);
    bus.halt_req = 1'b0;
    @(negedge clk);

    // BURST=200 aborted by HALT_REQ at burst cycle 10.
    bus.burst = 8'd200;
    bus.step_btn = 1'b1;
    lows = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      bus.step_btn = 1'b0;
      if (i >= 3 && !bus.cen) lows++;
    end
    exp_cnt = (exp_cnt + 1) % 16;
    chk("abort_cen_before", 32'(lows), 0);
    halt_pulse();
    chk("abort_cen", 32'(bus.cen), 0);
    chk("abort_step_active", 32'(bus.step_active), 0);
    chk("abort_running", 32'(bus.running), 0);
    chk("abort_cnt", 32'(bus.step_cnt), 32'(exp_cnt));

    // RUN pressed during burst cycle 20: seamless hand-over to RUN.
    bus.step_btn = 1'b1;
    lows = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      bus.step_btn = 1'b0;
      if (i >= 3 && !bus.cen) lows++;
      bus.run_btn = (i == 22);
    end
    exp_cnt = (exp_cnt + 1) % 16;
    chk("burst_to_run_gap", 32'(lows), 0);
    chk("burst_to_run_running", 32'(bus.running), 1);
    chk("burst_to_run_step_active", 32'(bus.step_active), 0);
    halt_pulse();
    chk("burst_to_run_halt", 32'(bus.cen), 0);
    @(negedge clk);

    // STEP held 60 cycles, BURST=2.
    bus.burst = 8'd2;
    bus.step_btn = 1'b1;
    nr = 0; prev = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (bus.cen && !prev && nr < 8) begin
        rise[nr] = i;
        nr++;
      end
      prev = bus.cen;
      if (i == 60) bus.step_btn = 1'b0;
    end
`ifdef STEP_AUTO_REPEAT_EN
    exp_rise = '{3, 25, 35, 45, 55};
    exp_cnt = (exp_cnt + 5) % 16;
    chk("repeat_bursts", 32'(nr), 5);
    for (int k = 0; k < 5; k++) chk($sformatf("repeat_start%0d", k), 32'(rise[k]), 32'(exp_rise[k]));
`else
    exp_rise = '{3, 0, 0, 0, 0};
    exp_cnt = (exp_cnt + 1) % 16;
    chk("held_bursts", 32'(nr), 1);
    chk("held_start0", 32'(rise[0]), 32'(exp_rise[0]));
`endif
    chk("held_cnt", 32'(bus.step_cnt), 32'(exp_cnt));
    chk("held_release_cen", 32'(bus.cen), 0);
    chk("held_release_active", 32'(bus.step_active), 0);

    // Counter wrap: 17 presses from reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.burst = 8'd1;
    for (int p = 1; p <= 17; p++) begin
      bus.step_btn = 1'b1;
      @(negedge clk);
      bus.step_btn = 1'b0;
      repeat (5) @(negedge clk);
      if (p == 15) chk("wrap_cnt15", 32'(bus.step_cnt), 15);
      if (p == 16) chk("wrap_cnt16", 32'(bus.step_cnt), 0);
      if (p == 17) chk("wrap_cnt17", 32'(bus.step_cnt), 1);
    end

    // Reset asserted mid-burst.
    bus.burst = 8'd50;
    step_watch(10, first, last, len, mism);
    chk("midrst_cen_before", 32'(bus.cen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cen", 32'(bus.cen), 0);
    chk("midrst_running", 32'(bus.running), 0);
    chk("midrst_step_active", 32'(bus.step_active), 0);
    chk("midrst_cnt", 32'(bus.step_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cen) lows++;
    end
    chk("midrst_discarded", 32'(lows), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
